// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader.
// Holds the controller state type, the clog2 helper used for width
// derivation, and the two supported BRAM read-latency settings.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // BRAM with output register enabled.
  localparam int HIGH_PERFORMANCE = 2;
  // BRAM without output register.
  localparam int LOW_LATENCY      = 1;

  // Ceiling log2, clamped to 1 so derived widths are never zero.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_stream_reader_chk.sv
// Checker for the BRAM stream reader: the output buffer must never be
// pushed while full, and the buffer occupancy can never exceed the
// credits handed out by the issue logic.
// Ports: clka/rstb clock and reset; push_i/pop_i/full_i buffer strobes;
// credit_i outstanding credits; count_i buffer occupancy.
module bram_stream_reader_chk #(
  parameter int CNT_W = 3
) (
  input logic             clka,
  input logic             rstb,
  input logic             push_i,
  input logic             pop_i,
  input logic             full_i,
  input logic [CNT_W-1:0] credit_i,
  input logic [CNT_W-1:0] count_i
);

  a_no_overflow: assert property (@(posedge clka) disable iff (rstb)
    !(push_i && full_i && !pop_i));

  a_count_within_credit: assert property (@(posedge clka) disable iff (rstb)
    (count_i <= credit_i));

endmodule

// File: rtl/rd_out_fifo.sv
// Synchronous output FIFO for the BRAM stream reader.
// Ports: clka/rstb clock and synchronous active-high reset; push_i and
// push_data_i write one entry; pop_i removes the head; head_o is the head
// entry (zero while empty); full_o/empty_o status; count_o occupancy.
module rd_out_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clka,
  input  logic             rstb,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];
  assign do_pop_s = pop_i & ~empty_o;
  // A push into a full buffer is only legal alongside a pop.
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clka) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side controller for a simple dual-port BRAM. A start command reads
// len consecutive words from base_addr (wrapping at RAM_DEPTH) and emits
// them as a valid/ready stream tagged with m_last on the final word.
// Ports: clka/rstb clock and synchronous active-high reset; start_i,
// base_addr_i, len_i command; busy_o/done_o status; bram_addrb_o,
// bram_enb_o, bram_regceb_o, bram_doutb_i BRAM read port; m_data_o,
// m_valid_o, m_last_o, m_ready_i output stream.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter  int RAM_WIDTH    = 32,
  parameter  int RAM_DEPTH    = 256,
  parameter  int READ_LATENCY = HIGH_PERFORMANCE,
  parameter  int BUF_DEPTH    = 4,
  parameter  int LEN_W        = 16,
  localparam int ADDR_W       = clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_W-1:0]    bram_addrb_o,
  output logic                 bram_enb_o,
  output logic                 bram_regceb_o,
  input  logic [RAM_WIDTH-1:0] bram_doutb_i,
  output logic [RAM_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  localparam int CRD_W  = clog2(BUF_DEPTH + 1);
  localparam int FIFO_W = RAM_WIDTH + 1;

  rd_state_e               state_q, state_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d, addrb_q, addrb_d;
  logic [LEN_W-1:0]        len_q, len_d, issued_q, issued_d;
  logic [CRD_W-1:0]        credit_q, credit_d;
  logic                    enb_q, enb_d, last_q, last_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d, pipe_lst_q, pipe_lst_d;

  logic                    issue_s, credit_ok_s, push_s, pop_s;
  logic [ADDR_W-1:0]       src_addr_s;
  logic [LEN_W-1:0]        src_cnt_s, src_len_s;
  logic [FIFO_W-1:0]       head_s;
  logic                    fifo_empty_s, fifo_full_s;
  logic [CRD_W-1:0]        fifo_count_s;

  // Credits cover both reads in flight and words parked in the FIFO, so a
  // read is only issued when its data is guaranteed a FIFO slot.
  assign credit_ok_s = (credit_q < CRD_W'(BUF_DEPTH));
  assign push_s      = pipe_vld_q[READ_LATENCY-1];
  assign pop_s       = ~fifo_empty_s & m_ready_i;

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bram_addrb_o  = addrb_q;
  assign bram_enb_o    = enb_q;
  assign bram_regceb_o = 1'b1;
  assign m_valid_o     = ~fifo_empty_s;
  assign m_data_o      = head_s[RAM_WIDTH-1:0];
  assign m_last_o      = head_s[RAM_WIDTH];

  // FSM next-state, issue decision and counter updates. The issue decision
  // is registered, so the read is presented on the BRAM port one cycle
  // after it is granted; the start cycle itself grants the first read.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    addrb_d    = addrb_q;
    enb_d      = 1'b0;
    last_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue_s    = 1'b0;
    src_addr_s = cur_addr_q;
    src_cnt_s  = issued_q;
    src_len_s  = len_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            len_d      = len_i;
            busy_d     = 1'b1;
            state_d    = ST_ISSUE;
            src_addr_s = base_addr_i;
            src_cnt_s  = '0;
            src_len_s  = len_i;
            issue_s    = credit_ok_s;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s = credit_ok_s;
      end
      ST_DRAIN: begin
        if (pop_s && head_s[RAM_WIDTH]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue_s) begin
      enb_d      = 1'b1;
      addrb_d    = src_addr_s;
      cur_addr_d = (src_addr_s == ADDR_W'(RAM_DEPTH - 1)) ? '0 : src_addr_s + ADDR_W'(1);
      issued_d   = src_cnt_s + LEN_W'(1);
      if (issued_d == src_len_s) begin
        last_d  = 1'b1;
        state_d = ST_DRAIN;
      end else begin
        last_d = 1'b0;
      end
    end else begin
      enb_d = 1'b0;
    end

    // A pop returns its credit at the next edge, never to the same-cycle grant.
    credit_d   = credit_q + CRD_W'(issue_s) - CRD_W'(pop_s);
    pipe_vld_d = (pipe_vld_q << 1) | READ_LATENCY'(enb_q);
    pipe_lst_d = (pipe_lst_q << 1) | READ_LATENCY'(last_q);
  end

  // Controller state, counters, BRAM port and in-flight tag pipe.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      credit_q   <= '0;
      addrb_q    <= '0;
      enb_q      <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pipe_vld_q <= '0;
      pipe_lst_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      credit_q   <= credit_d;
      addrb_q    <= addrb_d;
      enb_q      <= enb_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_lst_q <= pipe_lst_d;
    end
  end

  rd_out_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clka        (clka),
    .rstb        (rstb),
    .push_i      (push_s),
    .push_data_i ({pipe_lst_q[READ_LATENCY-1], bram_doutb_i}),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  bram_stream_reader_chk #(
    .CNT_W (CRD_W)
  ) u_chk (
    .clka     (clka),
    .rstb     (rstb),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .full_i   (fifo_full_s),
    .credit_i (credit_q),
    .count_i  (fifo_count_s)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a BRAM model feeds the DUT,
// expected addresses and words are queued when commands are issued, and a
// monitor pops and compares them whenever the DUT presents them.
module tb_bram_stream_reader;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 256;
  localparam int BUF_DEPTH = 4;
  localparam int LEN_W     = 16;
  localparam int ADDR_W    = 8;

  logic                 clka = 1'b0;
  logic                 rstb = 1'b1;
  logic                 start_i = 1'b0;
  logic [ADDR_W-1:0]    base_addr_i = '0;
  logic [LEN_W-1:0]     len_i = '0;
  logic                 busy_o, done_o, bram_enb_o, bram_regceb_o;
  logic [ADDR_W-1:0]    bram_addrb_o;
  logic [RAM_WIDTH-1:0] bram_doutb_i;
  logic [RAM_WIDTH-1:0] m_data_o;
  logic                 m_valid_o, m_last_o;
  logic                 m_ready_i = 1'b1;

  bram_stream_reader dut (
    .clka          (clka),
    .rstb          (rstb),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bram_addrb_o  (bram_addrb_o),
    .bram_enb_o    (bram_enb_o),
    .bram_regceb_o (bram_regceb_o),
    .bram_doutb_i  (bram_doutb_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // BRAM model: array read register plus a resettable output register.
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] bram_s1;
  always @(posedge clka) begin
    if (bram_enb_o) bram_s1 <= mem[bram_addrb_o];
    if (rstb) bram_doutb_i <= '0;
    else if (bram_regceb_o) bram_doutb_i <= bram_s1;
  end

  logic [RAM_WIDTH:0] exp_word_q [$];
  logic [ADDR_W-1:0]  exp_addr_q [$];

  int checks_total = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  int hs_cnt = 0, enb_cnt = 0, done_cnt = 0;
  int first_enb_cyc = -1, first_vld_cyc = -1, done_cyc = -1;
  bit any_busy = 0, any_enb = 0, any_valid = 0;

  initial begin : monitor
    bit prev_stall;
    logic [RAM_WIDTH-1:0] prev_data;
    logic prev_last;
    logic [RAM_WIDTH:0] w;
    logic [ADDR_W-1:0] a;
    prev_stall = 0;
    forever begin
      @(negedge clka);
      if (rstb) begin
        prev_stall = 0;
      end else begin
        if (busy_o) any_busy = 1;
        if (bram_enb_o) any_enb = 1;
        if (m_valid_o) any_valid = 1;
        if (m_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bram_enb_o) begin
          enb_cnt++;
          if (first_enb_cyc < 0) first_enb_cyc = cyc;
          check("addr_expected", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) begin
            a = exp_addr_q.pop_front();
            check("addrb", bram_addrb_o, a);
          end
        end
        if (prev_stall) begin
          check("stall_valid", m_valid_o, 1);
          check("stall_data", m_data_o, prev_data);
          check("stall_last", m_last_o, prev_last);
        end
        if (m_valid_o && m_ready_i) begin
          hs_cnt++;
          check("word_expected", exp_word_q.size() != 0, 1);
          if (exp_word_q.size() != 0) begin
            w = exp_word_q.pop_front();
            check("m_data", m_data_o, w[RAM_WIDTH-1:0]);
            check("m_last", m_last_o, w[RAM_WIDTH]);
          end
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Reference model: a command reads (base+i) mod depth for i in 0..len-1.
  task automatic issue_cmd(input logic [ADDR_W-1:0] base, input int len, output int c);
    int addr;
    start_i = 1'b1;
    base_addr_i = base;
    len_i = LEN_W'(len);
    c = cyc;
    for (int i = 0; i < len; i++) begin
      addr = (int'(base) + i) % RAM_DEPTH;
      exp_addr_q.push_back(ADDR_W'(addr));
      exp_word_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, mem[addr]});
    end
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd, input bit mid);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt > d0) begin
        seen = 1;
        break;
      end
      if (rnd) m_ready_i = 1'($urandom_range(0, 1));
      if (mid) begin
        start_i = (i == 10);
        if (i == 10) begin
          base_addr_i = 8'h33;
          len_i = 16'd5;
        end
      end
      tick();
    end
    start_i = 1'b0;
    m_ready_i = 1'b1;
    check("done_within_budget", seen, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c, h0, e0, d0;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);

    repeat (3) tick();
    rstb = 1'b0;
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_enb", bram_enb_o, 0);
    check("rst_addrb", bram_addrb_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_last", m_last_o, 0);
    check("rst_data", m_data_o, 0);
    check("regceb", bram_regceb_o, 1);

    // Basic read with exact latency.
    first_enb_cyc = -1; first_vld_cyc = -1; h0 = hs_cnt;
    issue_cmd(8'h10, 4, c);
    check("basic_busy", busy_o, 1);
    wait_done(40, 0, 0);
    check("basic_first_enb", first_enb_cyc, c + 1);
    check("basic_first_valid", first_vld_cyc, c + 4);
    check("basic_done_cycle", done_cyc, c + 8);
    check("basic_handshakes", hs_cnt - h0, 4);
    check("basic_busy_cleared", busy_o, 0);

    // Address wrap.
    h0 = hs_cnt; e0 = enb_cnt;
    issue_cmd(8'hFE, 4, c);
    wait_done(40, 0, 0);
    check("wrap_enb_count", enb_cnt - e0, 4);
    check("wrap_handshakes", hs_cnt - h0, 4);

    // Backpressure: credit limit and stable held data.
    h0 = hs_cnt; e0 = enb_cnt; d0 = done_cnt;
    m_ready_i = 1'b0;
    issue_cmd(8'h80, 16, c);
    repeat (20) tick();
    check("bp_credit_limit", (enb_cnt - e0) <= BUF_DEPTH, 1);
    check("bp_valid_held", m_valid_o, 1);
    check("bp_no_pop", hs_cnt - h0, 0);
    m_ready_i = 1'b1;
    wait_done(100, 0, 0);
    check("bp_handshakes", hs_cnt - h0, 16);
    check("bp_done_once", done_cnt - d0, 1);

    // Random ready, long command, ignored start mid-command.
    h0 = hs_cnt; d0 = done_cnt;
    issue_cmd(8'($urandom_range(0, 255)), 100, c);
    wait_done(1000, 1, 1);
    repeat (5) tick();
    check("rand_handshakes", hs_cnt - h0, 100);
    check("rand_done_once", done_cnt - d0, 1);
    check("rand_words_drained", exp_word_q.size(), 0);
    check("rand_addrs_drained", exp_addr_q.size(), 0);

    // Zero-length command.
    any_busy = 0; any_enb = 0; any_valid = 0; d0 = done_cnt;
    issue_cmd(8'h55, 0, c);
    repeat (5) tick();
    check("len0_done_cycle", done_cyc, c + 1);
    check("len0_done_once", done_cnt - d0, 1);
    check("len0_no_busy", any_busy, 0);
    check("len0_no_enb", any_enb, 0);
    check("len0_no_valid", any_valid, 0);

    // Reset during ISSUE with words buffered, then a clean command.
    m_ready_i = 1'b0;
    issue_cmd(8'h20, 16, c);
    repeat (5) tick();
    d0 = done_cnt;
    rstb = 1'b1;
    exp_word_q.delete();
    exp_addr_q.delete();
    tick();
    check("midrst_valid", m_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_enb", bram_enb_o, 0);
    check("midrst_done", done_o, 0);
    rstb = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    h0 = hs_cnt;
    issue_cmd(8'h40, 4, c);
    wait_done(40, 0, 0);
    check("postrst_handshakes", hs_cnt - h0, 4);
    check("postrst_words_drained", exp_word_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
